gshare_predictor: RTL and testbench
===================================

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameter: HIST_W, default 4; global history length and log2 of pattern table depth (table holds 2^HIST_W counters); legal range 2..12.
REQ-002 Parameter: CNT_W, default 2; saturating counter width; legal range 1..4.
REQ-003 Parameter: MODE, default 1; 1 = gshare (index = pc bits XOR history), 0 = bimodal (index = pc bits only).
REQ-004 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port: pred_valid, input, 1, lookup request this cycle.
REQ-007 Port: pred_pc, input, 32, branch instruction address; bits [HIST_W+1:2] used.
REQ-008 Port: pred_taken, output, 1, prediction: 1 = taken.
REQ-009 Port: pred_index, output, HIST_W, table index used for this lookup (carried down the pipe).
REQ-010 Port: pred_ghr, output, HIST_W, history value used for this lookup (checkpoint for repair).
REQ-011 Port: upd_valid, input, 1, branch resolved this cycle.
REQ-012 Port: upd_index, input, HIST_W, index returned from pred_index.
REQ-013 Port: upd_taken, input, 1, actual outcome.
REQ-014 Port: upd_mispredict, input, 1, resolved outcome differs from prediction; meaningful only with upd_valid.
REQ-015 Port: upd_ghr, input, HIST_W, checkpoint returned from pred_ghr.
REQ-016 Port: mispred_cnt, output, 16, count of upd_valid & upd_mispredict events.

Function
REQ-017 Lookup combinational, zero latency: index = pred_pc[HIST_W+1:2] ^ ghr (MODE=1) or pred_pc[HIST_W+1:2] (MODE=0).
REQ-018 pred_taken = MSB of selected counter; pred_index and pred_ghr reflect current-cycle index and ghr; outputs driven regardless of pred_valid.
REQ-019 Counter update on upd_valid: upd_taken = 1 increments, saturating at 2^CNT_W-1; upd_taken = 0 decrements, saturating at 0; only counter upd_index changes.
REQ-020 Read-before-write: lookup and update to the same index in one cycle; lookup returns pre-update counter value.
REQ-021 Speculative history: pred_valid and no mispredict repair -> ghr <= {ghr[HIST_W-2:0], pred_taken}.
REQ-022 Repair: upd_valid & upd_mispredict -> ghr <= {upd_ghr[HIST_W-2:0], upd_taken}; repair overrides a simultaneous speculative shift.
REQ-023 No pred_valid and no repair -> ghr holds.
REQ-024 In MODE=0, ghr is still maintained per REQ-021/022 but not used for indexing.
REQ-025 mispred_cnt increments by 1 per upd_valid & upd_mispredict; saturates at 16'hFFFF.
REQ-026 Correctly predicted updates (upd_mispredict = 0) train counters only; ghr is not touched.

Reset
REQ-027 rst_n low asynchronously sets all counters to weakly not-taken (2^(CNT_W-1)-1; 0 when CNT_W=1), ghr to 0, mispred_cnt to 0.
REQ-028 Reset mid-operation discards pending history and training; the first edge after deassertion behaves as a fresh start.
REQ-029 Out of reset with HIST_W=4, CNT_W=2: pred_taken = 0 for every pc; pred_ghr = 0.

Verification
REQ-030 Defaults, reset, pred_pc=0x10 -> pred_index=4, pred_taken=0; two upd_valid, upd_index=4, upd_taken=1 -> counter 3, pred_taken=1.
REQ-031 Saturation: five taken updates to index 2 then one not-taken -> counter 2, pred_taken=1; five not-taken -> counter 0, no underflow.
REQ-032 History: three pred_valid cycles predicting 1,0,1 -> ghr=4'b0101; next pred_pc=0x10 -> pred_index=4'b0001.
REQ-033 Repair with simultaneous lookup: ghr=4'b1111, pred_valid=1, upd_valid=1, upd_mispredict=1, upd_ghr=4'b0011, upd_taken=0 -> next ghr=4'b0110; mispred_cnt +1.
REQ-034 Same-index collision: counter 1, lookup and not-taken update to same index in one cycle -> pred_taken=0 that cycle, counter 0 after.
REQ-035 MODE=0: ghr=4'b1010, pred_pc=0x10 -> pred_index=4; assert rst_n low mid-sequence -> ghr, mispred_cnt, counters return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch direction predictor.
// A table of 2^HIST_W saturating counters is indexed either by pc bits XOR the
// speculative global history register (gshare) or by pc bits alone (bimodal).
// Lookup is combinational; training, history shifting and mispredict repair
// all happen on the rising clock edge.
module gshare_predictor #(
  parameter int HIST_W = 4,
  parameter int CNT_W  = 2,
  parameter int MODE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_index,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [HIST_W-1:0] upd_index,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  input  logic [HIST_W-1:0] upd_ghr,
  output logic [15:0]       mispred_cnt
);

  localparam int DEPTH = 1 << HIST_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // Weakly not-taken: all ones below the MSB (zero for a 1-bit counter).
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_MAX >> 1;

  logic [CNT_W-1:0]  cnt_tab [DEPTH];
  logic [HIST_W-1:0] ghr;
  logic [HIST_W-1:0] pc_bits;
  logic              repair;
  logic              pc_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign pc_bits   = pred_pc[HIST_W+1:2];
  assign pc_unused = ^{pred_pc[31:HIST_W+2], pred_pc[1:0]};
  assign repair    = upd_valid & upd_mispredict;

  // Combinational lookup; reads the pre-update counter on an index collision.
  always_comb begin
    pred_index = (MODE == 1) ? (pc_bits ^ ghr) : pc_bits;
    pred_taken = cnt_tab[pred_index][CNT_W-1];
    pred_ghr   = ghr;
  end

  // Train the resolved branch's counter toward its actual outcome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_tab[i] <= CNT_INIT;
    end else if (upd_valid) begin
      cnt_tab[upd_index] <= upd_taken ? sat_inc(cnt_tab[upd_index])
                                      : sat_dec(cnt_tab[upd_index]);
    end
  end

  // Global history: mispredict repair from the checkpoint wins over the
  // speculative shift of the current prediction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (repair) begin
      ghr <= {upd_ghr[HIST_W-2:0], upd_taken};
    end else if (pred_valid) begin
      ghr <= {ghr[HIST_W-2:0], pred_taken};
    end
  end

  // Saturating count of resolved mispredictions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_cnt <= '0;
    end else if (repair) begin
      mispred_cnt <= sat_inc16(mispred_cnt);
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: a gshare and a bimodal instance share stimulus.
module tb_gshare_predictor;

  logic        clk;
  logic        rst_n;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [3:0]  upd_index;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [3:0]  upd_ghr;

  logic        g_taken, b_taken;
  logic [3:0]  g_index, b_index, g_ghr, b_ghr;
  logic [15:0] g_mc, b_mc;

  int passed = 0;
  int total  = 0;

  gshare_predictor #(.HIST_W(4), .CNT_W(2), .MODE(1)) u_gsh (
    .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(g_taken), .pred_index(g_index), .pred_ghr(g_ghr),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr), .mispred_cnt(g_mc)
  );

  gshare_predictor #(.HIST_W(4), .CNT_W(2), .MODE(0)) u_bim (
    .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(b_taken), .pred_index(b_index), .pred_ghr(b_ghr),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr), .mispred_cnt(b_mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        uv;
    logic [3:0]  ui;
    logic        ut;
    logic        um;
    logic [3:0]  ug;
    logic        et;
    logic [3:0]  ei;
    logic [3:0]  eg;
    logic [15:0] emc;
  } vec_t;

  vec_t vecs[26];

  // Reference model: index 0 = gshare, 1 = bimodal.
  int mcnt[2][16];
  int mghr[2];
  int mmc[2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mkv(input logic pv, input logic [31:0] pc,
                               input logic uv, input logic [3:0] ui,
                               input logic ut, input logic um,
                               input logic [3:0] ug, input logic et,
                               input logic [3:0] ei, input logic [3:0] eg,
                               input logic [15:0] emc);
    vec_t v;
    v.pv = pv; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut; v.um = um;
    v.ug = ug; v.et = et; v.ei = ei; v.eg = eg; v.emc = emc;
    return v;
  endfunction

  task automatic drive(input logic pv, input logic [31:0] pc, input logic uv,
                       input logic [3:0] ui, input logic ut, input logic um,
                       input logic [3:0] ug);
    pred_valid = pv; pred_pc = pc; upd_valid = uv; upd_index = ui;
    upd_taken = ut; upd_mispredict = um; upd_ghr = ug;
  endtask

  task automatic do_reset();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) mcnt[m][i] = 1;
      mghr[m] = 0;
      mmc[m]  = 0;
    end
  endtask

  function automatic int m_idx(input int m, input logic [31:0] pc);
    int p;
    p = int'((pc >> 2) % 16);
    return (m == 0) ? (p ^ mghr[m]) : p;
  endfunction

  function automatic int m_taken(input int m, input logic [31:0] pc);
    return (mcnt[m][m_idx(m, pc)] >= 2) ? 1 : 0;
  endfunction

  task automatic model_update();
    int pt;
    for (int m = 0; m < 2; m++) begin
      pt = m_taken(m, pred_pc);
      if (upd_valid) begin
        if (upd_taken) mcnt[m][upd_index] = (mcnt[m][upd_index] < 3) ? mcnt[m][upd_index] + 1 : 3;
        else           mcnt[m][upd_index] = (mcnt[m][upd_index] > 0) ? mcnt[m][upd_index] - 1 : 0;
      end
      if (upd_valid && upd_mispredict) begin
        mghr[m] = ((int'(upd_ghr) * 2) + int'(upd_taken)) % 16;
        if (mmc[m] < 65535) mmc[m]++;
      end else if (pred_valid) begin
        mghr[m] = ((mghr[m] * 2) + pt) % 16;
      end
    end
  endtask

  initial begin
    // pv pc uv ui ut um ug | taken index ghr mispred_cnt (gshare instance)
    vecs[0]  = mkv(0, 32'h10, 0, 4'h0, 0, 0, 4'h0, 0, 4'h4, 4'h0, 16'd0);
    vecs[1]  = mkv(0, 32'h10, 1, 4'h4, 1, 0, 4'h0, 0, 4'h4, 4'h0, 16'd0);
    vecs[2]  = mkv(0, 32'h10, 1, 4'h4, 1, 0, 4'h0, 1, 4'h4, 4'h0, 16'd0);
    vecs[3]  = mkv(0, 32'h10, 0, 4'h0, 0, 0, 4'h0, 1, 4'h4, 4'h0, 16'd0);
    vecs[4]  = mkv(0, 32'h08, 1, 4'h2, 1, 0, 4'h0, 0, 4'h2, 4'h0, 16'd0);
    vecs[5]  = mkv(0, 32'h08, 1, 4'h2, 1, 0, 4'h0, 1, 4'h2, 4'h0, 16'd0);
    vecs[6]  = mkv(0, 32'h08, 1, 4'h2, 1, 0, 4'h0, 1, 4'h2, 4'h0, 16'd0);
    vecs[7]  = mkv(0, 32'h08, 1, 4'h2, 1, 0, 4'h0, 1, 4'h2, 4'h0, 16'd0);
    vecs[8]  = mkv(0, 32'h08, 1, 4'h2, 1, 0, 4'h0, 1, 4'h2, 4'h0, 16'd0);
    vecs[9]  = mkv(0, 32'h08, 1, 4'h2, 0, 0, 4'h0, 1, 4'h2, 4'h0, 16'd0);
    vecs[10] = mkv(0, 32'h08, 1, 4'h2, 0, 0, 4'h0, 1, 4'h2, 4'h0, 16'd0);
    vecs[11] = mkv(0, 32'h08, 1, 4'h2, 0, 0, 4'h0, 0, 4'h2, 4'h0, 16'd0);
    vecs[12] = mkv(0, 32'h08, 1, 4'h2, 0, 0, 4'h0, 0, 4'h2, 4'h0, 16'd0);
    vecs[13] = mkv(0, 32'h08, 1, 4'h2, 0, 0, 4'h0, 0, 4'h2, 4'h0, 16'd0);
    vecs[14] = mkv(0, 32'h08, 1, 4'h2, 0, 0, 4'h0, 0, 4'h2, 4'h0, 16'd0);
    vecs[15] = mkv(0, 32'h08, 1, 4'h2, 1, 0, 4'h0, 0, 4'h2, 4'h0, 16'd0);
    vecs[16] = mkv(0, 32'h08, 0, 4'h0, 0, 0, 4'h0, 0, 4'h2, 4'h0, 16'd0);
    vecs[17] = mkv(1, 32'h10, 0, 4'h0, 0, 0, 4'h0, 1, 4'h4, 4'h0, 16'd0);
    vecs[18] = mkv(1, 32'h0C, 0, 4'h0, 0, 0, 4'h0, 0, 4'h2, 4'h1, 16'd0);
    vecs[19] = mkv(1, 32'h18, 0, 4'h0, 0, 0, 4'h0, 1, 4'h4, 4'h2, 16'd0);
    vecs[20] = mkv(0, 32'h10, 0, 4'h0, 0, 0, 4'h0, 0, 4'h1, 4'h5, 16'd0);
    vecs[21] = mkv(0, 32'h10, 1, 4'hF, 1, 1, 4'h7, 0, 4'h1, 4'h5, 16'd0);
    vecs[22] = mkv(1, 32'h10, 1, 4'hF, 0, 1, 4'h3, 0, 4'hB, 4'hF, 16'd1);
    vecs[23] = mkv(0, 32'h10, 1, 4'h2, 0, 0, 4'h0, 0, 4'h2, 4'h6, 16'd2);
    vecs[24] = mkv(0, 32'h10, 1, 4'h2, 1, 0, 4'h0, 0, 4'h2, 4'h6, 16'd2);
    vecs[25] = mkv(0, 32'h10, 0, 4'h0, 0, 0, 4'h0, 0, 4'h2, 4'h6, 16'd2);

    rst_n = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    #2;
    do_reset();

    // Out of reset every pc predicts not-taken with empty history.
    for (int i = 0; i < 4; i++) begin
      pred_pc = 32'h10 * i + 32'h4;
      #2;
      chk("reset_g_taken", g_taken, 0);
      chk("reset_b_taken", b_taken, 0);
    end
    chk("reset_g_ghr", g_ghr, 0);
    chk("reset_g_mc", g_mc, 0);
    @(posedge clk); #1;

    // Directed table on the gshare instance.
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].pv, vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].ut,
            vecs[i].um, vecs[i].ug);
      #4;
      chk($sformatf("v%0d_taken", i), g_taken, vecs[i].et);
      chk($sformatf("v%0d_index", i), g_index, vecs[i].ei);
      chk($sformatf("v%0d_ghr", i), g_ghr, vecs[i].eg);
      chk($sformatf("v%0d_mc", i), g_mc, vecs[i].emc);
      @(posedge clk); #1;
    end

    // Bimodal indexing ignores history, then asynchronous reset mid-cycle.
    do_reset();
    drive(0, 32'h10, 1, 4'h0, 0, 1, 4'h5);
    @(posedge clk); #1;
    drive(0, 32'h10, 1, 4'h4, 1, 0, 4'h0);
    #4;
    chk("bim_index", b_index, 4);
    chk("bim_ghr", b_ghr, 4'hA);
    chk("gsh_index_hist", g_index, 4'hE);
    @(posedge clk); #1;
    drive(0, 32'h10, 1, 4'h4, 1, 0, 4'h0);
    @(posedge clk); #1;
    drive(0, 32'h10, 0, 4'h0, 0, 0, 4'h0);
    #4;
    chk("bim_trained_taken", b_taken, 1);
    chk("bim_mc_before", b_mc, 1);
    rst_n = 1'b0;
    #1;
    chk("async_b_ghr", b_ghr, 0);
    chk("async_b_mc", b_mc, 0);
    chk("async_b_taken", b_taken, 0);
    chk("async_g_ghr", g_ghr, 0);
    chk("async_g_mc", g_mc, 0);
    chk("async_g_index", g_index, 4);
    chk("async_g_taken", g_taken, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic against the reference model, with one reset midway.
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        model_reset();
      end
      drive(1'($urandom_range(0, 1)), {24'h0, 8'($urandom)},
            1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), 4'($urandom));
      #4;
      chk("rnd_g_taken", g_taken, m_taken(0, pred_pc));
      chk("rnd_g_index", g_index, m_idx(0, pred_pc));
      chk("rnd_g_ghr", g_ghr, mghr[0]);
      chk("rnd_g_mc", g_mc, mmc[0]);
      chk("rnd_b_taken", b_taken, m_taken(1, pred_pc));
      chk("rnd_b_index", b_index, m_idx(1, pred_pc));
      chk("rnd_b_ghr", b_ghr, mghr[1]);
      chk("rnd_b_mc", b_mc, mmc[1]);
      @(posedge clk);
      model_update();
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
